// File: rtl/punc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : punc_pkg
// Description : Shared state encodings, LC3 opcodes, datapath select codes
//               and instruction-field helpers for the PUnC multi-cycle control.
// Revision    : 1.0 - initial multi-cycle controller release
// ============================================================================
package punc_pkg;

  localparam logic [2:0] c_st_fetch  = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec1  = 3'd2;
  localparam logic [2:0] c_st_exec2  = 3'd3;
  localparam logic [2:0] c_st_halt   = 3'd4;

  localparam logic [3:0] c_op_br   = 4'b0000;
  localparam logic [3:0] c_op_add  = 4'b0001;
  localparam logic [3:0] c_op_ld   = 4'b0010;
  localparam logic [3:0] c_op_st   = 4'b0011;
  localparam logic [3:0] c_op_jsr  = 4'b0100;
  localparam logic [3:0] c_op_and  = 4'b0101;
  localparam logic [3:0] c_op_ldr  = 4'b0110;
  localparam logic [3:0] c_op_str  = 4'b0111;
  localparam logic [3:0] c_op_rti  = 4'b1000;
  localparam logic [3:0] c_op_not  = 4'b1001;
  localparam logic [3:0] c_op_ldi  = 4'b1010;
  localparam logic [3:0] c_op_sti  = 4'b1011;
  localparam logic [3:0] c_op_jmp  = 4'b1100;
  localparam logic [3:0] c_op_res  = 4'b1101;
  localparam logic [3:0] c_op_lea  = 4'b1110;
  localparam logic [3:0] c_op_halt = 4'b1111;

  localparam logic [1:0] c_addr_pc  = 2'd0;
  localparam logic [1:0] c_addr_alu = 2'd1;
  localparam logic [1:0] c_addr_ind = 2'd2;

  localparam logic [1:0] c_wsel_pc  = 2'd0;
  localparam logic [1:0] c_wsel_mem = 2'd1;
  localparam logic [1:0] c_wsel_alu = 2'd2;

  localparam logic [1:0] c_imm_5 = 2'd0;
  localparam logic [1:0] c_imm_6 = 2'd1;
  localparam logic [1:0] c_imm_9 = 2'd2;

  localparam logic [1:0] c_alu_add  = 2'd0;
  localparam logic [1:0] c_alu_and  = 2'd1;
  localparam logic [1:0] c_alu_pass = 2'd2;
  localparam logic [1:0] c_alu_not  = 2'd3;

  function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [2:0] ir_dr(input logic [15:0] ir);
    return ir[11:9];
  endfunction

  function automatic logic [2:0] ir_sr1(input logic [15:0] ir);
    return ir[8:6];
  endfunction

  function automatic logic [2:0] ir_sr2(input logic [15:0] ir);
    return ir[2:0];
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == c_op_ld)  || (op == c_op_ldr) || (op == c_op_ldi) ||
           (op == c_op_st)  || (op == c_op_str) || (op == c_op_sti);
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == c_op_st) || (op == c_op_str) || (op == c_op_sti);
  endfunction

endpackage
`default_nettype wire

// File: rtl/punc_mem_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : punc_mem_watchdog
// Description : Counts stalled memory-request cycles and flags a timeout.
// Revision    : 1.0 - initial multi-cycle controller release
// ============================================================================
module punc_mem_watchdog #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ack,
  input  logic state_chg,
  output logic timeout
);

  generate
    if (WAIT_MAX == 0) begin : g_disabled
      logic w_unused_wd;
      assign w_unused_wd = clk ^ rst ^ mem_req ^ mem_ack ^ state_chg;
      assign timeout     = 1'b0;
    end else begin : g_enabled
      localparam int c_cnt_w = $clog2(WAIT_MAX + 1);
      logic [c_cnt_w-1:0] r_wait_cnt;

      // A stray ack with no request outstanding must not disturb the count
      always_ff @(posedge clk) begin
        if (rst || (mem_req && mem_ack) || state_chg) begin
          r_wait_cnt <= '0;
        end else if (mem_req) begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end

      assign timeout = mem_req && !mem_ack &&
                       (r_wait_cnt == c_cnt_w'(WAIT_MAX));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/punc_control_mc.sv
`default_nettype none
// ============================================================================
// Module      : punc_control_mc
// Description : Multi-cycle LC3 control FSM with handshaked memory access,
//               timeout watchdog, HALT/run control and retire counter.
// Revision    : 1.0 - initial multi-cycle controller release
// ============================================================================
module punc_control_mc
  import punc_pkg::*;
#(
  parameter int WAIT_MAX  = 15,
  parameter int RET_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          ir,
  input  logic                 n,
  input  logic                 z,
  input  logic                 p,
  input  logic                 mem_ack,
  input  logic                 run,
  output logic                 pc_clr,
  output logic                 pc_inc,
  output logic                 pc_ld,
  output logic                 pc_data_sel,
  output logic                 pc_add_sel,
  output logic                 ir_ld,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [1:0]           addr_sel,
  output logic                 ind_ld,
  output logic                 rf_we,
  output logic [2:0]           rf_waddr,
  output logic [2:0]           rf_raddr0,
  output logic [2:0]           rf_raddr1,
  output logic [1:0]           rf_wsel,
  output logic                 a_sel,
  output logic                 b_sel,
  output logic [1:0]           imm_sel,
  output logic [1:0]           alu_op,
  output logic                 nzp_sel,
  output logic                 nzp_ld,
  output logic                 halted,
  output logic                 fault,
  output logic [RET_CNT_W-1:0] retired,
  output logic [2:0]           state_dbg
);

  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic                 r_fault;
  logic [RET_CNT_W-1:0] r_retired;
  logic [3:0]           w_opcode;
  logic                 w_mem_op;
  logic                 w_timeout;
  logic                 w_retire;
  logic                 w_set_fault;
  logic                 w_clr_fault;
  logic                 w_alu_wb;
  logic                 w_ld_wb;
  logic                 w_unused_ir;

  assign w_opcode    = ir_opcode(ir);
  assign w_mem_op    = is_mem_op(w_opcode);
  assign w_unused_ir = ^ir[4:3];

  // Request is a pure function of state so the watchdog sees no loop back
  assign mem_req = !rst && ((r_state == c_st_fetch) || (r_state == c_st_exec2) ||
                            ((r_state == c_st_exec1) && w_mem_op));

  punc_mem_watchdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .state_chg (w_state_nxt != r_state),
    .timeout   (w_timeout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_set_fault = 1'b0;
    w_clr_fault = 1'b0;
    w_alu_wb    = 1'b0;
    w_ld_wb     = 1'b0;
    pc_inc      = 1'b0;
    pc_ld       = 1'b0;
    pc_data_sel = 1'b0;
    pc_add_sel  = 1'b0;
    ir_ld       = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = c_addr_pc;
    ind_ld      = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = 3'd0;
    rf_raddr0   = 3'd0;
    rf_raddr1   = 3'd0;
    rf_wsel     = c_wsel_pc;
    a_sel       = 1'b0;
    b_sel       = 1'b0;
    imm_sel     = c_imm_5;
    alu_op      = c_alu_add;
    nzp_sel     = 1'b0;
    nzp_ld      = 1'b0;
    halted      = 1'b0;

    if (!rst) begin
      case (r_state)
        c_st_fetch: begin
          if (mem_ack) begin
            ir_ld       = 1'b1;
            pc_inc      = 1'b1;
            w_state_nxt = c_st_decode;
          end
        end

        c_st_decode: begin
          if (w_opcode == c_op_halt) begin
            w_retire    = 1'b1;
            w_state_nxt = c_st_halt;
          end else if ((w_opcode == c_op_rti) || (w_opcode == c_op_res)) begin
            w_set_fault = 1'b1;
            w_state_nxt = c_st_halt;
          end else begin
            w_state_nxt = c_st_exec1;
          end
        end

        c_st_exec1: begin
          case (w_opcode)
            c_op_add, c_op_and: begin
              rf_raddr0 = ir_sr1(ir);
              rf_raddr1 = ir_sr2(ir);
              a_sel     = 1'b1;
              b_sel     = ir[5];
              imm_sel   = c_imm_5;
              alu_op    = (w_opcode == c_op_and) ? c_alu_and : c_alu_add;
              w_alu_wb  = 1'b1;
            end
            c_op_not: begin
              rf_raddr0 = ir_sr1(ir);
              a_sel     = 1'b1;
              alu_op    = c_alu_not;
              w_alu_wb  = 1'b1;
            end
            c_op_lea: begin
              b_sel    = 1'b1;
              imm_sel  = c_imm_9;
              w_alu_wb = 1'b1;
            end
            c_op_br: begin
              pc_add_sel = 1'b1;
              pc_ld      = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
            end
            c_op_jmp: begin
              rf_raddr0   = ir_sr1(ir);
              a_sel       = 1'b1;
              alu_op      = c_alu_pass;
              pc_ld       = 1'b1;
              pc_data_sel = 1'b1;
            end
            c_op_jsr: begin
              rf_we    = 1'b1;
              rf_waddr = 3'd7;
              rf_wsel  = c_wsel_pc;
              pc_ld    = 1'b1;
              if (!ir[11]) begin
                rf_raddr0   = ir_sr1(ir);
                a_sel       = 1'b1;
                alu_op      = c_alu_pass;
                pc_data_sel = 1'b1;
              end
            end
            c_op_ld, c_op_ldi, c_op_st, c_op_sti: begin
              b_sel    = 1'b1;
              imm_sel  = c_imm_9;
              addr_sel = c_addr_alu;
            end
            c_op_ldr, c_op_str: begin
              rf_raddr0 = ir_sr1(ir);
              a_sel     = 1'b1;
              b_sel     = 1'b1;
              imm_sel   = c_imm_6;
              addr_sel  = c_addr_alu;
            end
            default: ;
          endcase

          if (is_store_op(w_opcode)) begin
            rf_raddr1 = ir_dr(ir);
          end

          if (!w_mem_op) begin
            w_retire    = 1'b1;
            w_state_nxt = c_st_fetch;
          end else if (mem_ack) begin
            if ((w_opcode == c_op_ldi) || (w_opcode == c_op_sti)) begin
              ind_ld      = 1'b1;
              w_state_nxt = c_st_exec2;
            end else begin
              w_ld_wb     = !is_store_op(w_opcode);
              mem_we      = is_store_op(w_opcode);
              w_retire    = 1'b1;
              w_state_nxt = c_st_fetch;
            end
          end
        end

        c_st_exec2: begin
          addr_sel = c_addr_ind;
          if (w_opcode == c_op_sti) begin
            rf_raddr1 = ir_dr(ir);
          end
          if (mem_ack) begin
            w_ld_wb     = (w_opcode != c_op_sti);
            mem_we      = (w_opcode == c_op_sti);
            w_retire    = 1'b1;
            w_state_nxt = c_st_fetch;
          end
        end

        c_st_halt: begin
          halted = 1'b1;
          if (run) begin
            w_clr_fault = 1'b1;
            w_state_nxt = c_st_fetch;
          end
        end

        default: w_state_nxt = c_st_fetch;
      endcase

      if (w_alu_wb || w_ld_wb) begin
        rf_we    = 1'b1;
        rf_waddr = ir_dr(ir);
        rf_wsel  = w_ld_wb ? c_wsel_mem : c_wsel_alu;
        nzp_ld   = 1'b1;
        nzp_sel  = w_ld_wb;
      end

      // Timeout only fires without an ack, so no commit strobe is live here
      if (w_timeout) begin
        w_set_fault = 1'b1;
        w_state_nxt = c_st_halt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_fetch;
      r_fault   <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_fault) begin
        r_fault <= 1'b1;
      end else if (w_clr_fault) begin
        r_fault <= 1'b0;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  assign pc_clr    = rst;
  assign fault     = r_fault && !rst;
  assign retired   = rst ? '0 : r_retired;
  assign state_dbg = rst ? 3'd0 : r_state;

endmodule
`default_nettype wire
